sum_collector: RTL

SUM_COLLECTOR -- requirements
Module: sum_collector

---
 rtl/sum_collector.sv | 115 +++++++++++
 1 files changed

// File: rtl/sum_collector.sv
// sum_collector: accumulates COUNT unsigned 5-bit adder results into one
// ACC_W-bit block total, with a valid/ready handshake on each side.
// The block total is held until downstream takes it.
// Optional build macro SUM_COLLECTOR_SAT_EN: clamp the total at
// 2^ACC_W-1 on overflow instead of wrapping modulo 2^ACC_W.
module sum_collector #(
    parameter int COUNT = 4,
    parameter int ACC_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;

    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_xfer;

    // Reduce the one-bit-wider sum back to ACC_W bits: clamp or wrap.
    function automatic logic [ACC_W-1:0] fold_sum(input logic [ACC_W:0] s);
`ifdef SUM_COLLECTOR_SAT_EN
        // Once clamped at all-ones, any further non-zero sample carries
        // again, so the total stays clamped for the rest of the block.
        if (s[ACC_W])
            fold_sum = {ACC_W{1'b1}};
        else
            fold_sum = s[ACC_W-1:0];
`else
        fold_sum = s[ACC_W-1:0];
`endif
    endfunction

    // in_ready is a pure state decode so it never depends on in_valid.
    assign in_ready  = (state != HOLD);
    assign in_xfer   = in_valid && in_ready;
    assign sum_ext   = {1'b0, acc} + (ACC_W + 1)'(in_sum);
    assign cnt_inc   = cnt + 1'b1;

    assign out_valid = (state == HOLD);
    assign out_acc   = acc;
    assign out_ovf   = ovf;
    assign busy      = (state != IDLE);

    // Next-state and next-register values; default is hold everything.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    acc_nxt   = ACC_W'(in_sum);
                    cnt_nxt   = CNT_W'(1);
                    ovf_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    acc_nxt = fold_sum(sum_ext);
                    ovf_nxt = ovf | sum_ext[ACC_W];
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LAST)
                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Upstream data offered on the release cycle is not taken.
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and block registers; reset discards any partial or held total.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule
